// File: rtl/pic_w_datapath_if.sv
// ---------------------------------------------------------------------------
// pic_w_datapath_if
// Bus between the instruction decoder and the W datapath core.
//   inst     decoder -> core   ALU opcode
//   f        decoder -> core   file-register operand F
//   counter  core -> decoder   free-running program counter
//   w        core -> decoder   working register
//   carry    core -> decoder   registered carry/borrow flag
//   ans      core -> decoder   combinational ALU result, top bit is carry-out
// The master modport is the decoder side; the slave modport is the core.
// ---------------------------------------------------------------------------
interface pic_w_datapath_if #(
   parameter int WIDTH = 16,
   parameter int OPW   = 4
);
   logic [OPW-1:0]   inst;
   logic [WIDTH-1:0] f;
   logic [WIDTH-1:0] counter;
   logic [WIDTH-1:0] w;
   logic             carry;
   logic [WIDTH:0]   ans;

   modport master (
      output inst, f,
      input  counter, w, carry, ans
   );

   modport slave (
      input  inst, f,
      output counter, w, carry, ans
   );
endinterface

// File: rtl/pic_w_datapath.sv
// ---------------------------------------------------------------------------
// pic_w_datapath
// Accumulator datapath core: free-running program counter, combinational
// opcode ALU combining W with operand F, and the W register plus carry flag
// which reload from the ALU result on every clock.
// Ports:
//   clk    in   single clock, rising edge
//   reset  in   asynchronous, active-low reset (0 = reset)
//   bus    slave side of pic_w_datapath_if (inst, f in; counter, w,
//          carry, ans out)
// ---------------------------------------------------------------------------
module pic_w_datapath #(
   parameter int WIDTH = 16,
   parameter int OPW   = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   pic_w_datapath_if.slave       bus
);

   typedef enum logic [OPW-1:0] {
      OP_LOAD = 4'd0,
      OP_ADD  = 4'd1,
      OP_SUB  = 4'd2,
      OP_AND  = 4'd3,
      OP_OR   = 4'd4,
      OP_XOR  = 4'd5,
      OP_NOT  = 4'd6,
      OP_INC  = 4'd7,
      OP_DEC  = 4'd8,
      OP_SHL  = 4'd9,
      OP_SHR  = 4'd10,
      OP_CLR  = 4'd11
   } opcode_t;

   localparam logic [WIDTH-1:0] ONE_W   = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [WIDTH:0]   ONE_ANS = {{WIDTH{1'b0}}, 1'b1};

   logic [WIDTH-1:0] r_counter;
   logic [WIDTH-1:0] r_w;
   logic             r_carry;

   logic [WIDTH:0]   w_wExt;
   logic [WIDTH:0]   w_fExt;
   logic [WIDTH:0]   w_alu;
   logic [WIDTH:0]   w_ans;

   assign w_wExt = {1'b0, r_w};
   assign w_fExt = {1'b0, bus.f};

   // ALU: operands are zero-extended so the top bit of every arithmetic
   // result is the carry (ADD/INC) or borrow (SUB/DEC). The default arm
   // doubles as the NOP group and catches unknown opcodes, so W is held.
   always_comb begin
      w_alu = w_wExt;
      case (bus.inst)
         OP_LOAD: w_alu = w_fExt;
         OP_ADD:  w_alu = w_wExt + w_fExt;
         OP_SUB:  w_alu = w_wExt - w_fExt;
         OP_AND:  w_alu = w_wExt & w_fExt;
         OP_OR:   w_alu = w_wExt | w_fExt;
         OP_XOR:  w_alu = w_wExt ^ w_fExt;
         OP_NOT:  w_alu = {1'b0, ~r_w};
         OP_INC:  w_alu = w_wExt + ONE_ANS;
         OP_DEC:  w_alu = w_wExt - ONE_ANS;
         OP_SHL:  w_alu = {r_w, 1'b0};
         OP_SHR:  w_alu = {r_w[0], 1'b0, r_w[WIDTH-1:1]};
         OP_CLR:  w_alu = '0;
         default: w_alu = w_wExt;
      endcase
   end

   // The result is gated to zero while reset is held so that the decoder
   // never sees a stale value during reset.
   assign w_ans = reset ? w_alu : '0;

   // Program counter: counts every edge out of reset, wrapping naturally.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_counter <= '0;
      end else begin
         r_counter <= r_counter + ONE_W;
      end
   end

   // W and carry reload from the ALU on every edge; holding W means the
   // decoder must issue a NOP.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_w     <= '0;
         r_carry <= 1'b0;
      end else begin
         r_w     <= w_ans[WIDTH-1:0];
         r_carry <= w_ans[WIDTH];
      end
   end

   assign bus.counter = r_counter;
   assign bus.w       = r_w;
   assign bus.carry   = r_carry;
   assign bus.ans     = w_ans;

endmodule

// File: tb/tb_pic_w_datapath.sv
// ---------------------------------------------------------------------------
// tb_pic_w_datapath
// Directed, table-driven bench for pic_w_datapath plus hand-written sequences
// for reset, counter wrap and asynchronous reset.
// ---------------------------------------------------------------------------
module tb_pic_w_datapath;

   typedef struct {
      logic [3:0]  inst;
      logic [15:0] f;
      logic [16:0] expAns;
      logic [15:0] expW;
      logic        expCarry;
   } vector_t;

   localparam int NVEC = 24;

   logic clk;
   logic reset;
   int   vecCount;
   int   errCount;
   vector_t vec [NVEC];

   pic_w_datapath_if #(.WIDTH(16), .OPW(4)) bus ();

   pic_w_datapath #(.WIDTH(16), .OPW(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic applyStimulus(input logic [3:0] inst, input logic [15:0] f);
      bus.inst = inst;
      bus.f    = f;
   endtask

   task automatic checkOutput(input string name, input logic [16:0] actual,
                              input logic [16:0] expected);
      vecCount++;
      if (actual !== expected) begin
         errCount++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   initial begin
      vecCount = 0;
      errCount = 0;

      // Chained vectors: each row starts from the W/carry left by the one
      // before, beginning with W=0 after reset.
      vec[0]  = '{4'd0,  16'h000A, 17'h0000A, 16'h000A, 1'b0};
      vec[1]  = '{4'd1,  16'h000A, 17'h00014, 16'h0014, 1'b0};
      vec[2]  = '{4'd2,  16'h000A, 17'h0000A, 16'h000A, 1'b0};
      vec[3]  = '{4'd0,  16'h0003, 17'h00003, 16'h0003, 1'b0};
      vec[4]  = '{4'd2,  16'h0004, 17'h1FFFF, 16'hFFFF, 1'b1};
      vec[5]  = '{4'd0,  16'hFFFF, 17'h0FFFF, 16'hFFFF, 1'b0};
      vec[6]  = '{4'd1,  16'h0001, 17'h10000, 16'h0000, 1'b1};
      vec[7]  = '{4'd0,  16'h0003, 17'h00003, 16'h0003, 1'b0};
      vec[8]  = '{4'd4,  16'h0001, 17'h00003, 16'h0003, 1'b0};
      vec[9]  = '{4'd5,  16'h0004, 17'h00007, 16'h0007, 1'b0};
      vec[10] = '{4'd0,  16'h0003, 17'h00003, 16'h0003, 1'b0};
      vec[11] = '{4'd9,  16'h1234, 17'h00006, 16'h0006, 1'b0};
      vec[12] = '{4'd0,  16'h0003, 17'h00003, 16'h0003, 1'b0};
      vec[13] = '{4'd10, 16'h5555, 17'h10001, 16'h0001, 1'b1};
      vec[14] = '{4'd3,  16'h0003, 17'h00001, 16'h0001, 1'b0};
      vec[15] = '{4'd6,  16'hABCD, 17'h0FFFE, 16'hFFFE, 1'b0};
      vec[16] = '{4'd7,  16'h0000, 17'h0FFFF, 16'hFFFF, 1'b0};
      vec[17] = '{4'd7,  16'h0000, 17'h10000, 16'h0000, 1'b1};
      vec[18] = '{4'd8,  16'h0000, 17'h1FFFF, 16'hFFFF, 1'b1};
      vec[19] = '{4'd8,  16'h0000, 17'h0FFFE, 16'hFFFE, 1'b0};
      vec[20] = '{4'd11, 16'h0005, 17'h00000, 16'h0000, 1'b0};
      vec[21] = '{4'd0,  16'h0014, 17'h00014, 16'h0014, 1'b0};
      vec[22] = '{4'd12, 16'h0007, 17'h00014, 16'h0014, 1'b0};
      vec[23] = '{4'd15, 16'hFFFF, 17'h00014, 16'h0014, 1'b0};

      // Reset held from time 0: everything must already be zero.
      reset = 1'b0;
      applyStimulus(4'd1, 16'h0055);
      #2;
      checkOutput("reset_counter", {1'b0, bus.counter}, 17'h0);
      checkOutput("reset_w",       {1'b0, bus.w},       17'h0);
      checkOutput("reset_carry",   {16'h0, bus.carry},  17'h0);
      checkOutput("reset_ans",     bus.ans,             17'h0);

      // Release between edges, then three edges count 1, 2, 3.
      @(negedge clk);
      applyStimulus(4'd12, 16'h0000);
      reset = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         @(posedge clk);
         #1;
         checkOutput($sformatf("counter_%0d", i), {1'b0, bus.counter}, 17'(i));
      end

      // Pulse reset low between edges: clear must be immediate.
      @(negedge clk);
      reset = 1'b0;
      #1;
      checkOutput("pulse_counter", {1'b0, bus.counter}, 17'h0);
      checkOutput("pulse_w",       {1'b0, bus.w},       17'h0);
      checkOutput("pulse_carry",   {16'h0, bus.carry},  17'h0);
      #1;
      reset = 1'b1;

      // Vector table.
      for (int i = 0; i < NVEC; i++) begin
         @(negedge clk);
         applyStimulus(vec[i].inst, vec[i].f);
         #1;
         checkOutput($sformatf("v%0d_ans", i), bus.ans, vec[i].expAns);
         @(posedge clk);
         #1;
         checkOutput($sformatf("v%0d_w", i),     {1'b0, bus.w},      {1'b0, vec[i].expW});
         checkOutput($sformatf("v%0d_carry", i), {16'h0, bus.carry}, {16'h0, vec[i].expCarry});
      end

      // Async reset mid-cycle with W=20 and ADD pending.
      @(negedge clk);
      applyStimulus(4'd1, 16'h0005);
      #1;
      checkOutput("pre_async_ans", bus.ans, 17'h00019);
      #1;
      reset = 1'b0;
      #1;
      checkOutput("async_w",       {1'b0, bus.w},       17'h0);
      checkOutput("async_carry",   {16'h0, bus.carry},  17'h0);
      checkOutput("async_counter", {1'b0, bus.counter}, 17'h0);
      checkOutput("async_ans",     bus.ans,             17'h0);

      // First edge after release loads ans computed from W=0.
      @(negedge clk);
      reset = 1'b1;
      #1;
      checkOutput("release_ans", bus.ans, 17'h00005);
      @(posedge clk);
      #1;
      checkOutput("release_w",       {1'b0, bus.w},       17'h0005);
      checkOutput("release_counter", {1'b0, bus.counter}, 17'h0001);

      // Counter wrap: run up to FFFF from a fresh reset, then one more edge.
      @(negedge clk);
      applyStimulus(4'd12, 16'h0000);
      reset = 1'b0;
      #1;
      reset = 1'b1;
      repeat (65535) @(posedge clk);
      #1;
      checkOutput("counter_ffff", {1'b0, bus.counter}, 17'h0FFFF);
      @(posedge clk);
      #1;
      checkOutput("counter_wrap", {1'b0, bus.counter}, 17'h0);
      @(posedge clk);
      #1;
      checkOutput("counter_after_wrap", {1'b0, bus.counter}, 17'h1);

      $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
      $finish;
   end

endmodule
